// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon button input stage.
// Button indices, encoder FSM state type and the default debounce depth.
package simon_pkg;

    localparam logic [1:0] BTN_GREEN  = 2'd0;
    localparam logic [1:0] BTN_RED    = 2'd1;
    localparam logic [1:0] BTN_YELLOW = 2'd2;
    localparam logic [1:0] BTN_BLUE   = 2'd3;

    localparam int DEBOUNCE_TICKS_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        PRESSED,
        RELQ
    } state_t;

    // One-hot button pattern that corresponds to a button index.
    function automatic logic [3:0] btn_mask(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/simon_btn_sync.sv
// Two-flop synchronizer for the four raw player buttons.
// Only instantiated when SIMON_BTN_SYNC_EN is defined.
module simon_btn_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_btn,
    output logic [3:0] o_btn
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    assign o_btn = r_sync;

endmodule

// File: rtl/simon_button_encoder.sv
// Debounces four player buttons into an index plus a level "pressed" flag.
// Define SIMON_BTN_SYNC_EN to put a 2-flop synchronizer in front of the FSM.
module simon_button_encoder
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       lock,
    output logic [1:0] player_num,
    output logic       player_pressed,
    output logic       press_pulse
);

    localparam int             CW      = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [3:0]    w_btn;
    logic          w_single;
    logic [1:0]    w_idx;

    state_t        r_state,   w_state_next;
    logic [CW-1:0] r_cnt,     w_cnt_next;
    logic [1:0]    r_cand,    w_cand_next;
    logic [1:0]    r_num,     w_num_next;
    logic          r_pressed, w_pressed_next;
    logic          r_pulse,   w_pulse_next;

`ifdef SIMON_BTN_SYNC_EN
    simon_btn_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .i_btn (btn),
        .o_btn (w_btn)
    );
`else
    assign w_btn = btn;
`endif

    // Exactly one button high yields a valid index; anything else is rejected.
    always_comb begin
        w_single = 1'b1;
        w_idx    = BTN_GREEN;
        case (w_btn)
            4'b0001: w_idx = BTN_GREEN;
            4'b0010: w_idx = BTN_RED;
            4'b0100: w_idx = BTN_YELLOW;
            4'b1000: w_idx = BTN_BLUE;
            default: w_single = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_cand_next    = r_cand;
        w_num_next     = r_num;
        w_pressed_next = r_pressed;
        w_pulse_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!lock && w_single) begin
                    w_cand_next  = w_idx;
                    w_cnt_next   = CNT_ONE;
                    w_state_next = QUAL;
                end
            end
            QUAL: begin
                if (lock || (w_btn != btn_mask(r_cand))) begin
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next   = PRESSED;
                    w_num_next     = r_cand;
                    w_pressed_next = 1'b1;
                    w_pulse_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            // Lock and other buttons are ignored once a press is owned.
            PRESSED: begin
                if (!w_btn[r_cand]) begin
                    w_cnt_next   = CNT_ONE;
                    w_state_next = RELQ;
                end
            end
            RELQ: begin
                if (w_btn[r_cand]) begin
                    w_cnt_next   = '0;
                    w_state_next = PRESSED;
                end else if (r_cnt == CNT_MAX) begin
                    w_cnt_next     = '0;
                    w_pressed_next = 1'b0;
                    w_state_next   = IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cand    <= BTN_GREEN;
            r_num     <= BTN_GREEN;
            r_pressed <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_cand    <= w_cand_next;
            r_num     <= w_num_next;
            r_pressed <= w_pressed_next;
            r_pulse   <= w_pulse_next;
        end
    end

    assign player_num     = r_num;
    assign player_pressed = r_pressed;
    assign press_pulse    = r_pulse;

endmodule
